// File: rtl/fetch_stage_pkg.sv
// Shared opcode constants, fetch state encoding and PC helpers.
// Also used by the decoder. The optional fetch counter is enabled by
// defining FETCH_PERF_CNT_EN; it is handled in fetch_stage.sv.
package fetch_stage_pkg;

  localparam logic [4:0]  OPC_HALT  = 5'b00000;
  localparam logic [4:0]  OPC_NOP   = 5'b00001;
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] PC_INC    = 16'h0002;
  localparam logic [15:0] NOP_INSTR = {OPC_NOP, 11'b000_0000_0000};

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_t;

  // Sequential PC: 16-bit modulo, so 0xFFFE wraps to 0x0000 silently.
  function automatic logic [15:0] pc_advance(input logic [15:0] pc);
    return pc + PC_INC;
  endfunction

  // True when the word carries the HALT opcode.
  function automatic logic is_halt_word(input logic [15:0] word);
    return (word[15:11] == OPC_HALT);
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: synchronous reset to RESET_PC, load-enable.
import fetch_stage_pkg::*;

module pc_reg (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  output logic [15:0] o_pc
);

  logic [15:0] r_pc;

  // Hold the PC unless a load is requested; reset wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else begin
      r_pc <= r_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Single-cycle instruction fetch stage with IF/ID register and HALT freeze.
// Priority per edge: rst > redirect > stall > halted > normal fetch.
// Optional retired-fetch counter enabled by defining FETCH_PERF_CNT_EN.
import fetch_stage_pkg::*;

module fetch_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_data,
  output logic [15:0] o_instr,
  output logic [4:0]  o_opcode,
  output logic [15:0] o_pc_plus2,
  output logic        o_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] o_fetch_count,
`endif
  output logic        o_halted
);

  fetch_state_t r_state;
  logic [15:0]  r_instr;
  logic [15:0]  r_pc_plus2;
  logic         r_valid;
  logic         r_halted;

  logic [15:0]  w_pc;
  logic [15:0]  w_pc_inc;
  logic [15:0]  w_redirect_pc;
  logic         w_pc_load;
  logic [15:0]  w_pc_val;
  logic         w_fetch;

  assign w_pc_inc      = pc_advance(w_pc);
  // Instructions are halfword aligned: bit 0 of a redirect target is dropped.
  assign w_redirect_pc = i_redirect_pc & 16'hFFFE;
  // A normal fetch cycle is the only case that loads valid with 1.
  assign w_fetch       = ~i_redirect & ~i_stall & (r_state == ST_FETCH);

  // Next-PC selection; reset is applied inside pc_reg.
  always_comb begin
    w_pc_load = 1'b0;
    w_pc_val  = w_pc_inc;
    if (i_redirect) begin
      w_pc_load = 1'b1;
      w_pc_val  = w_redirect_pc;
    end else if (i_stall) begin
      w_pc_load = 1'b0;
    end else if (r_state == ST_HALT) begin
      w_pc_load = 1'b0;
    end else if (is_halt_word(i_imem_data)) begin
      w_pc_load = 1'b0;
    end else begin
      w_pc_load = 1'b1;
    end
  end

  pc_reg u_pc_reg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_pc_load),
    .i_load_val (w_pc_val),
    .o_pc       (w_pc)
  );

  // FETCH/HALT state machine and IF/ID register update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_FETCH;
      r_instr    <= NOP_INSTR;
      r_pc_plus2 <= RESET_PC;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else if (i_redirect) begin
      // Squash the wrong path, including a captured HALT.
      r_state    <= ST_FETCH;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else if (i_stall) begin
      r_state    <= r_state;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_instr    <= i_imem_data;
          r_pc_plus2 <= w_pc_inc;
          r_valid    <= 1'b1;
          if (is_halt_word(i_imem_data)) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state  <= ST_FETCH;
            r_halted <= 1'b0;
          end
        end
        ST_HALT: begin
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= ST_FETCH;
          r_valid  <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  // Count every edge that loads a real instruction into IF/ID.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_count <= 32'd0;
    end else if (w_fetch) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end else begin
      r_fetch_count <= r_fetch_count;
    end
  end

  assign o_fetch_count = r_fetch_count;
`else
  logic w_fetch_unused;
  assign w_fetch_unused = w_fetch;
`endif

  assign o_imem_addr = w_pc;
  assign o_instr     = r_instr;
  assign o_opcode    = r_instr[15:11];
  assign o_pc_plus2  = r_pc_plus2;
  assign o_valid     = r_valid;
  assign o_halted    = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [4:0]  opcode;
  logic [15:0] pc_plus2;
  logic        valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int n_vec;
  int n_err;

  fetch_stage dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_addr   (imem_addr),
    .i_imem_data   (imem_data),
    .o_instr       (instr),
    .o_opcode      (opcode),
    .o_pc_plus2    (pc_plus2),
    .o_valid       (valid),
`ifdef FETCH_PERF_CNT_EN
    .o_fetch_count (fetch_count),
`endif
    .o_halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word = 0x4000 + addr, except a HALT word at 0x0010.
  always_comb begin
    if (imem_addr == 16'h0010) imem_data = 16'h0000;
    else                       imem_data = imem_addr + 16'h4000;
  end

  // chk bit0: instr/opcode, bit1: pc_plus2
  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pp2;
    logic        valid;
    logic        halted;
    logic [1:0]  chk;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [15:0] p);
    rst = r; stall = s; redirect = rd; redirect_pc = p;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic s, input logic rd, input logic [15:0] p,
                     input logic [15:0] a, input logic [15:0] i, input logic [15:0] pp,
                     input logic v, input logic h, input logic [1:0] c);
    vec_t t;
    t.rst = r; t.stall = s; t.redirect = rd; t.rpc = p;
    t.addr = a; t.instr = i; t.pp2 = pp; t.valid = v; t.halted = h; t.chk = c;
    vq.push_back(t);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

    //   rst   stl   rdr   rpc       addr      instr     pp2       v     h     chk
    add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 2'b11);
    add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 2'b11);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0, 2'b11);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h4002, 16'h0004, 1'b1, 1'b0, 2'b11);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 16'h4004, 16'h0006, 1'b1, 1'b0, 2'b11);
    for (int k = 0; k < 3; k++)
      add(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0006, 16'h4004, 16'h0006, 1'b1, 1'b0, 2'b11);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0008, 16'h4006, 16'h0008, 1'b1, 1'b0, 2'b11);
    // redirect with stall in the same cycle: redirect wins, bit 0 dropped
    add(1'b0, 1'b1, 1'b1, 16'h1235, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1236, 16'h5234, 16'h1236, 1'b1, 1'b0, 2'b11);
    // HALT at 0x0010
    add(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0012, 1'b1, 1'b1, 2'b11);
    for (int k = 0; k < 5; k++)
      add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'b01);
    add(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'b01);
    add(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0022, 16'h4020, 16'h0022, 1'b1, 1'b0, 2'b11);
    // wrap: 0xFFFF -> 0xFFFE -> 0x0000
    add(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h3FFE, 16'h0000, 1'b1, 1'b0, 2'b11);
    // rst beats stall
    add(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 2'b11);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0, 2'b11);
    // rst while halted, and rst beats redirect
    add(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0012, 1'b1, 1'b1, 2'b11);
    add(1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 2'b11);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h4000, 16'h0002, 1'b1, 1'b0, 2'b11);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].stall, vq[i].redirect, vq[i].rpc);
      check($sformatf("v%0d.addr", i), {16'h0000, imem_addr}, {16'h0000, vq[i].addr});
      check($sformatf("v%0d.valid", i), {31'd0, valid}, {31'd0, vq[i].valid});
      check($sformatf("v%0d.halted", i), {31'd0, halted}, {31'd0, vq[i].halted});
      if (vq[i].chk[0]) begin
        check($sformatf("v%0d.instr", i), {16'h0000, instr}, {16'h0000, vq[i].instr});
        check($sformatf("v%0d.opcode", i), {27'd0, opcode}, {27'd0, vq[i].instr[15:11]});
      end
      if (vq[i].chk[1])
        check($sformatf("v%0d.pc_plus2", i), {16'h0000, pc_plus2}, {16'h0000, vq[i].pp2});
`ifdef FETCH_PERF_CNT_EN
      if (vq[i].rst)
        check($sformatf("v%0d.fetch_count", i), fetch_count, 32'd0);
`endif
    end

    // Redirect under stall, then stall held: bubble and target PC persist.
    drive(1'b0, 1'b1, 1'b1, 16'h0100);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0000);
      check("seq_stall_bubble.addr", {16'h0000, imem_addr}, 32'h0000_0100);
      check("seq_stall_bubble.valid", {31'd0, valid}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    check("seq_resume.instr", {16'h0000, instr}, 32'h0000_4100);
    check("seq_resume.pc_plus2", {16'h0000, pc_plus2}, 32'h0000_0102);
    check("seq_resume.valid", {31'd0, valid}, 32'd1);

`ifdef FETCH_PERF_CNT_EN
    // 10 fetches, 2 stalls, 1 redirect -> count of 10; then reset clears it.
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    check("cnt_reset", fetch_count, 32'd0);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 16'h0200);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 16'h0000);
    check("cnt_after_mix", fetch_count, 32'd10);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    check("cnt_cleared", fetch_count, 32'd0);
`endif

    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
- REQ-001: clk  input  1  sole clock; all state updates on rising edge.
- REQ-002: rst  input  1  synchronous, active-high reset.
- REQ-003: stall  input  1  decode hold request; freezes PC and IF/ID contents.
- REQ-004: redirect  input  1  taken branch/jump from downstream; flushes and reloads PC.
- REQ-005: redirect_pc  input  16  target address for redirect.
- REQ-006: imem_addr  output  16  instruction memory address; equals current PC combinationally.
- REQ-007: imem_data  input  16  instruction word, valid the same cycle as imem_addr.
- REQ-008: instr  output  16  IF/ID instruction register.
- REQ-009: opcode  output  5  instr[15:11], driven to the decoder opcode input.
- REQ-010: pc_plus2  output  16  IF/ID copy of fetch PC + 2, used for link and displacement targets.
- REQ-011: valid  output  1  IF/ID holds a real instruction; 0 means bubble.
- REQ-012: halted  output  1  HALT captured; fetch frozen.
- REQ-013: fetch_count  output  32  retired-fetch counter; present only under FETCH_PERF_CNT_EN.

Function
- REQ-014: Fetch latency is one cycle: the word at imem_addr in cycle N appears on instr in cycle N+1.
- REQ-015: Normal cycle (no rst, no redirect, no stall, not halted) SHALL do: instr<=imem_data; pc_plus2<=PC+2; valid<=1; PC<=PC+2.
- REQ-016: PC arithmetic is 16-bit modulo: PC 0xFFFE advances to 0x0000 with no flag.
- REQ-017: Redirect SHALL do: PC<=redirect_pc with bit0 forced to 0; valid<=0; halted<=0; instr and pc_plus2 are don't-care.
- REQ-018: Priority: rst > redirect > stall > halted > normal.
- REQ-019: Stall without redirect SHALL hold PC, instr, pc_plus2, valid and halted unchanged.
- REQ-020: HALT is detected when imem_data[15:11]==OPC_HALT in a normal cycle: the word is captured with valid<=1, halted<=1 and PC unchanged.
- REQ-021: While halted, with no redirect and no stall: PC held, valid<=0 (bubbles), instr held.
- REQ-022: A redirect while halted SHALL resume fetch from redirect_pc on the next cycle, because a wrong-path HALT is squashed.
- REQ-023: Simultaneous stall and redirect: the redirect is applied and the stall is ignored for that cycle.
- REQ-024: State machine is two states: FETCH (halted=0) and HALT (halted=1). FETCH->HALT on REQ-020; HALT->FETCH on redirect or rst.

Reset
- REQ-025: rst SHALL set PC=RESET_PC (0x0000), instr=16'h0800 (NOP), pc_plus2=0x0000, valid=0, halted=0, fetch_count=0.
- REQ-026: rst asserted mid-stall, mid-redirect or while halted SHALL take precedence and apply REQ-025 at the next edge.
- REQ-027: In the first cycle after rst deasserts, imem_addr SHALL be 0x0000.

Configuration
- REQ-028: With FETCH_PERF_CNT_EN defined, fetch_count increments by 1 on every edge where valid is loaded with 1, and wraps at 2^32.
- REQ-029: With FETCH_PERF_CNT_EN undefined, the fetch_count port and its counter are absent; all other behaviour is identical.

Structure
- REQ-030: OPC_HALT (5'b00000), OPC_NOP (5'b00001), RESET_PC and PC_INC (2) SHALL live in the shared opcode constants package, shared with the decoder.
- REQ-031: The PC SHALL be a separate sub-module pc_reg: 16-bit, with sync reset, load-enable and load-value; the IF/ID registers stay inline.

Verification
- REQ-032: rst for 2 cycles, then release; imem returns 0x4000+addr -> imem_addr sequence 0,2,4; instr 0x4000,0x4002 with valid=1 from cycle 2.
- REQ-033: stall high for 3 cycles at PC=0x0006 -> imem_addr stays 0x0006; instr, valid and pc_plus2=0x0006 unchanged; after release, instr=word@0x0006.
- REQ-034: redirect=1, redirect_pc=0x1235, with stall=1 in the same cycle -> next imem_addr=0x1234, valid=0; following cycle instr=word@0x1234.
- REQ-035: word 0x0000 at 0x0010 -> instr=0x0000, valid=1, halted=1; then valid=0 with imem_addr=0x0010 for 5 cycles; redirect to 0x0020 -> halted=0, fetch resumes at 0x0020.
- REQ-036: PC preloaded via redirect to 0xFFFE -> next imem_addr=0x0000, pc_plus2=0x0000.
- REQ-037: With FETCH_PERF_CNT_EN, 10 normal fetches, 2 stalls and 1 redirect -> fetch_count=10; rst -> fetch_count=0.
